fl_vadd_arbiter: RTL and testbench
==================================

Name: fl_vadd_arbiter

Overview:
- Shares one fl_vadd vector-add datapath between N_REQ requesters, each supplying a paired x/y element stream delimited by an end flag.
- Grants whole vectors (packets) round-robin and forwards the granted requester's streams to the datapath.
- Records each grant's requester ID in an order (tag) FIFO, then steers the datapath result stream back to the owning requester.
- Sits between the requester-side AXI-Stream-like interfaces and a single fl_vadd instance.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, element width
- TAG_DEPTH, 8, outstanding vectors tracked (power of 2)
- CNT_W, 16, per-side beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_x_data  in  N_REQ*DATA_WIDTH  x elements, requester i at slice i
- req_x_valid  in  N_REQ  x valid per requester
- req_x_ready  out  N_REQ  x ready per requester
- req_x_end  in  N_REQ  last x element of vector
- req_y_data, req_y_valid, req_y_ready, req_y_end  as x, for the y stream
- rsp_data  out  DATA_WIDTH  result element, broadcast to all requesters
- rsp_end  out  1  last result of vector, broadcast
- rsp_valid  out  N_REQ  result valid, one-hot to the owning requester
- rsp_ready  in  N_REQ  result ready per requester
- dp_x_data/dp_x_valid/dp_x_end  out  DATA_WIDTH/1/1  to datapath x
- dp_x_ready  in  1
- dp_y_data/dp_y_valid/dp_y_end  out  DATA_WIDTH/1/1  to datapath y
- dp_y_ready  in  1
- dp_out_data  in  DATA_WIDTH  datapath result
- dp_out_valid  in  1
- dp_out_end  in  1
- dp_out_ready  out  1
- busy  out  1  high in state BUSY
- grant_id  out  $clog2(N_REQ)  current or last granted requester
- len_err  out  1  sticky: x/y beat counts differed in a granted vector

Behaviour:
- Reset: state IDLE, rr pointer 0, tag FIFO empty, counters 0, len_err 0, grant_id 0.
- Reset also forces all ready/valid outputs to 0 and holds them there while rst is high.
- Reset mid-packet abandons the packet. The datapath must be reset by the same rst.
- Request: req[i] = req_x_valid[i] & req_y_valid[i].
- IDLE:
  - If any req and the tag FIFO is not full, select the first requesting index at or after the rr pointer, wrapping modulo N_REQ.
  - Register the selection as grant_id, push it to the tag FIFO, clear x_done/y_done/counters, go to BUSY.
  - Grant takes effect the next cycle. No forwarding occurs in IDLE.
- BUSY, forwarding is combinational with zero added latency:
  - dp_x_* = req_x_* of grant_id, gated so dp_x_valid=0 once x_done.
  - req_x_ready[grant_id] = dp_x_ready & !x_done. All other req_x_ready are 0.
  - y side is identical.
- A beat transfers on valid&ready and increments the side's counter.
  - A transferred beat with end set sets x_done or y_done.
  - If both sides end in the same cycle, both done flags set together.
- When x_done & y_done (including a same-cycle double end):
  - Compare the counters. If unequal, set len_err (cleared only by rst).
  - Advance the rr pointer to grant_id+1 mod N_REQ and return to IDLE.
  - Minimum gap between packets is 1 IDLE cycle.
- Counters saturate at 2^CNT_W-1.
- Return path, independent of grant state:
  - If the tag FIFO is not empty, head tag h gives rsp_valid[h] = dp_out_valid and dp_out_ready = rsp_ready[h].
  - rsp_data = dp_out_data, rsp_end = dp_out_end.
  - If the tag FIFO is empty, dp_out_ready=0 and rsp_valid=0.
  - The tag pops on dp_out_valid & dp_out_ready & dp_out_end.
  - Push and pop in the same cycle are legal, including when the FIFO is full: the pop frees space, but the grant still sees registered full, so no push occurs that cycle.
- Tag FIFO full: IDLE stalls, with no grant, until a pop.

Decomposition:
- Package fl_vadd_arb_pkg:
  - state enum {IDLE, BUSY}
  - IDX_W = $clog2(N_REQ) helper
  - round-robin next-index function
- Sub-module fl_vadd_arb_tag_fifo: synchronous tag FIFO, width IDX_W, depth TAG_DEPTH, synchronous active-high reset, first-word fall-through head, full/empty flags.

Test Plan:
- Single requester 0 sends 4-element x/y, datapath echoes x+y with 10-cycle latency.
  - Required: grant_id=0, busy high 4+ cycles, rsp_valid=4'b0001 for 4 beats, rsp_end on the 4th beat, tag FIFO empty afterwards.
- Requesters 1 and 3 request in the same cycle after reset.
  - Required: 1 granted first, then 3. Results return in order 1 then 3 on rsp_valid bits 1 and 3.
- Requester 2 x-end arrives 3 cycles before y-end.
  - Required: req_x_ready[2]=0 after x end, BUSY held until y end, then IDLE and rr pointer=3.
- TAG_DEPTH=2, datapath output held not-ready, three requesters queue.
  - Required: third grant withheld until the first vector's dp_out_end pops a tag.
- rsp_ready[0] toggles 1/0 during a 6-element result.
  - Required: dp_out_ready mirrors it, no beat lost or duplicated.
- Requester 0 sends 5 x and 4 y elements: len_err=1 and stays 1 until rst.
- rst asserted mid-packet: the next cycle has busy=0, all ready and rsp_valid outputs 0, and grant_id=0.

Source files
------------

// File: rtl/fl_vadd_arb_pkg.sv
// Shared types and helpers for the fl_vadd request arbiter.
package fl_vadd_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next round-robin starting point after index idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fl_vadd_arb_tag_fifo.sv
// Order FIFO holding requester IDs of granted vectors; head is visible
// without a read request so the return path can steer immediately.
module fl_vadd_arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fl_vadd_arbiter.sv
// Packet-level round-robin arbiter sharing one fl_vadd datapath; result
// beats are steered back to their owner using the grant-order tag FIFO.
module fl_vadd_arbiter
  import fl_vadd_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_x_data,
  input  logic [N_REQ-1:0]            req_x_valid,
  output logic [N_REQ-1:0]            req_x_ready,
  input  logic [N_REQ-1:0]            req_x_end,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_y_data,
  input  logic [N_REQ-1:0]            req_y_valid,
  output logic [N_REQ-1:0]            req_y_ready,
  input  logic [N_REQ-1:0]            req_y_end,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_end,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]       dp_x_data,
  output logic                        dp_x_valid,
  output logic                        dp_x_end,
  input  logic                        dp_x_ready,
  output logic [DATA_WIDTH-1:0]       dp_y_data,
  output logic                        dp_y_valid,
  output logic                        dp_y_end,
  input  logic                        dp_y_ready,
  input  logic [DATA_WIDTH-1:0]       dp_out_data,
  input  logic                        dp_out_valid,
  input  logic                        dp_out_end,
  output logic                        dp_out_ready,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        len_err
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d, grant_q, grant_d;
  logic             x_done_q, x_done_d, y_done_q, y_done_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic             len_err_q, len_err_d;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] pick_idx, scan_idx;
  logic             pick_found, grant_go, fwd_act, ret_act;
  logic             x_fire, y_fire, tag_pop, tag_full, tag_empty;
  logic [IDX_W-1:0] tag_head;

  assign req      = req_x_valid & req_y_valid;
  assign busy     = (state_q == ST_BUSY);
  assign grant_id = grant_q;
  assign len_err  = len_err_q;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign grant_go = (state_q == ST_IDLE) && pick_found && !tag_full && !rst;

  // Forward path: rst forces every handshake output low.
  assign fwd_act    = busy && !rst;
  assign dp_x_data  = req_x_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign dp_y_data  = req_y_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign dp_x_end   = req_x_end[grant_q];
  assign dp_y_end   = req_y_end[grant_q];
  assign dp_x_valid = fwd_act && !x_done_q && req_x_valid[grant_q];
  assign dp_y_valid = fwd_act && !y_done_q && req_y_valid[grant_q];
  assign x_fire     = dp_x_valid && dp_x_ready;
  assign y_fire     = dp_y_valid && dp_y_ready;

  always_comb begin
    req_x_ready = '0;
    req_y_ready = '0;
    req_x_ready[grant_q] = fwd_act && dp_x_ready && !x_done_q;
    req_y_ready[grant_q] = fwd_act && dp_y_ready && !y_done_q;
  end

  // Return path follows the tag FIFO head regardless of grant state.
  assign ret_act      = !tag_empty && !rst;
  assign rsp_data     = dp_out_data;
  assign rsp_end      = dp_out_end;
  assign dp_out_ready = ret_act && rsp_ready[tag_head];
  assign tag_pop      = dp_out_valid && dp_out_ready && dp_out_end;

  always_comb begin
    rsp_valid = '0;
    rsp_valid[tag_head] = ret_act && dp_out_valid;
  end

  fl_vadd_arb_tag_fifo #(
    .W     (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (grant_go),
    .data_i  (pick_idx),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    x_done_d  = x_done_q;
    y_done_d  = y_done_q;
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    len_err_d = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_go) begin
          grant_d  = pick_idx;
          x_done_d = 1'b0;
          y_done_d = 1'b0;
          x_cnt_d  = '0;
          y_cnt_d  = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (x_fire) begin
          x_cnt_d  = (&x_cnt_q) ? x_cnt_q : x_cnt_q + 1'b1;
          x_done_d = x_done_q | dp_x_end;
        end
        if (y_fire) begin
          y_cnt_d  = (&y_cnt_q) ? y_cnt_q : y_cnt_q + 1'b1;
          y_done_d = y_done_q | dp_y_end;
        end
        if (x_done_d && y_done_d) begin
          if (x_cnt_d != y_cnt_d) len_err_d = 1'b1;
          rr_d    = IDX_W'(rr_next(int'(grant_q), N_REQ));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      x_done_q  <= 1'b0;
      y_done_q  <= 1'b0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      x_done_q  <= x_done_d;
      y_done_q  <= y_done_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: tb/tb_fl_vadd_arbiter.sv
// Directed bench for fl_vadd_arbiter with a behavioural x+y datapath
// (10-cycle latency) and hand-computed expected result streams.
module tb_fl_vadd_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TD  = 2;
  localparam int CW  = 16;
  localparam int TMO = 300;

  typedef struct packed {
    logic [31:0]   t;
    logic          e;
    logic [DW-1:0] d;
  } ob_t;

  logic clk = 1'b0;
  logic rst;
  logic [N*DW-1:0] req_x_data, req_y_data;
  logic [N-1:0]    req_x_valid, req_x_ready, req_x_end;
  logic [N-1:0]    req_y_valid, req_y_ready, req_y_end;
  logic [DW-1:0]   rsp_data;
  logic            rsp_end;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   dp_x_data, dp_y_data;
  logic            dp_x_valid, dp_x_end, dp_y_valid, dp_y_end;
  logic            dp_x_ready = 1'b1;
  logic            dp_y_ready = 1'b1;
  logic [DW-1:0]   dp_out_data = '0;
  logic            dp_out_valid = 1'b0;
  logic            dp_out_end = 1'b0;
  logic            dp_out_ready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            len_err;

  logic [DW-1:0] xd [N];
  logic [DW-1:0] yd [N];
  logic          xv [N];
  logic          xe [N];
  logic          yv [N];
  logic          ye [N];

  logic [DW:0]   xq [$];
  logic [DW:0]   yq [$];
  ob_t           outq [$];
  logic [63:0]   rlog [$];
  logic [63:0]   elog [$];
  int            glog [$];
  int            gcyc [$];

  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   first_pop = -1;
  int   pid;
  bit   busy_prev = 0;
  bit   chk_mirror = 0;
  bit   toggle_en = 0;
  logic [DW:0] xb_t, yb_t;
  ob_t  ob_t_v;

  always #5 clk = ~clk;

  always_comb begin
    req_x_data  = '0;
    req_y_data  = '0;
    req_x_valid = '0;
    req_y_valid = '0;
    req_x_end   = '0;
    req_y_end   = '0;
    for (int i = 0; i < N; i++) begin
      req_x_data[i*DW +: DW] = xd[i];
      req_y_data[i*DW +: DW] = yd[i];
      req_x_valid[i] = xv[i];
      req_y_valid[i] = yv[i];
      req_x_end[i]   = xe[i];
      req_y_end[i]   = ye[i];
    end
  end

  fl_vadd_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .TAG_DEPTH  (TD),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_x_data   (req_x_data),
    .req_x_valid  (req_x_valid),
    .req_x_ready  (req_x_ready),
    .req_x_end    (req_x_end),
    .req_y_data   (req_y_data),
    .req_y_valid  (req_y_valid),
    .req_y_ready  (req_y_ready),
    .req_y_end    (req_y_end),
    .rsp_data     (rsp_data),
    .rsp_end      (rsp_end),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .dp_x_data    (dp_x_data),
    .dp_x_valid   (dp_x_valid),
    .dp_x_end     (dp_x_end),
    .dp_x_ready   (dp_x_ready),
    .dp_y_data    (dp_y_data),
    .dp_y_valid   (dp_y_valid),
    .dp_y_end     (dp_y_end),
    .dp_y_ready   (dp_y_ready),
    .dp_out_data  (dp_out_data),
    .dp_out_valid (dp_out_valid),
    .dp_out_end   (dp_out_end),
    .dp_out_ready (dp_out_ready),
    .busy         (busy),
    .grant_id     (grant_id),
    .len_err      (len_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [63:0] enc(input int id, input logic e, input int d);
    logic [3:0] idb;
    idb = id[3:0];
    return {27'd0, idb, e, d[31:0]};
  endfunction

  task automatic exp_push(input int id, input logic e, input int d);
    elog.push_back(enc(id, e, d));
  endtask

  // Sample just before each rising edge: datapath model and result monitor.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      xq.delete();
      yq.delete();
      outq.delete();
      busy_prev = 1'b0;
    end else begin
      if (dp_x_valid && dp_x_ready) xq.push_back({dp_x_end, dp_x_data});
      if (dp_y_valid && dp_y_ready) yq.push_back({dp_y_end, dp_y_data});
      if (dp_out_valid && dp_out_ready) begin
        pid = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) pid = i;
        check_val("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
        rlog.push_back(enc(pid, rsp_end, int'(rsp_data)));
        if (outq.size() > 0) void'(outq.pop_front());
        if (rsp_end && first_pop < 0) first_pop = cyc;
      end
      while (xq.size() > 0 && yq.size() > 0) begin
        xb_t = xq.pop_front();
        yb_t = yq.pop_front();
        ob_t_v.t = 32'(cyc + 10);
        ob_t_v.e = xb_t[DW];
        ob_t_v.d = xb_t[DW-1:0] + yb_t[DW-1:0];
        outq.push_back(ob_t_v);
      end
      if (busy && !busy_prev) begin
        glog.push_back(int'(grant_id));
        gcyc.push_back(cyc);
      end
      busy_prev = busy;
      if (busy) busy_cnt++;
      if (chk_mirror && dp_out_valid) check_val("mirror", 64'(dp_out_ready), 64'(rsp_ready[0]));
    end
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (outq.size() > 0 && int'(outq[0].t) <= cyc) begin
      dp_out_valid = 1'b1;
      dp_out_data  = outq[0].d;
      dp_out_end   = outq[0].e;
    end else begin
      dp_out_valid = 1'b0;
      dp_out_data  = '0;
      dp_out_end   = 1'b0;
    end
    if (toggle_en) rsp_ready[0] = ~rsp_ready[0];
  end

  // Drives one stream of one requester; called at a falling edge.
  task automatic drive_side(input int id, input bit is_y, input int n, input int base, input int gap);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gap > 0 && k == n - 1 && k > 0) begin
        if (is_y) yv[id] = 1'b0; else xv[id] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      if (is_y) begin
        yd[id] = DW'(base + k); ye[id] = (k == n - 1); yv[id] = 1'b1;
      end else begin
        xd[id] = DW'(base + k); xe[id] = (k == n - 1); xv[id] = 1'b1;
      end
      #1;
      t = 0;
      while (!(is_y ? req_y_ready[id] : req_x_ready[id]) && t < TMO) begin
        @(negedge clk);
        #1;
        t++;
      end
      check_val($sformatf("rdy_wait_r%0d", id), 64'(t < TMO), 64'd1);
      @(negedge clk);
    end
    if (is_y) begin yv[id] = 1'b0; ye[id] = 1'b0; end
    else begin xv[id] = 1'b0; xe[id] = 1'b0; end
  endtask

  task automatic send(input int id, input int nx, input int ny, input int xbase, input int ybase);
    fork
      drive_side(id, 1'b0, nx, xbase, 0);
      drive_side(id, 1'b1, ny, ybase, 0);
    join
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rlog.delete();
    elog.delete();
    glog.delete();
    gcyc.delete();
    first_pop = -1;
    busy_cnt = 0;
  endtask

  task automatic wait_rsp(input string tag);
    int t;
    t = 0;
    while (rlog.size() < elog.size() && t < TMO) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check_val({tag, "_count"}, 64'(rlog.size()), 64'(elog.size()));
    for (int i = 0; i < elog.size(); i++)
      if (i < rlog.size()) check_val($sformatf("%s_beat%0d", tag, i), rlog[i], elog[i]);
  endtask

  task automatic check_grant(input string tag, input int idx, input int exp);
    check_val(tag, (idx < glog.size()) ? 64'(glog[idx]) : 64'hDEAD, 64'(exp));
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      xd[i] = '0; yd[i] = '0; xv[i] = 1'b0; yv[i] = 1'b0; xe[i] = 1'b0; ye[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_grant", 64'(grant_id), 64'd0);
    check_val("rst_xready", 64'(req_x_ready), 64'd0);
    check_val("rst_rspvalid", 64'(rsp_valid), 64'd0);
    check_val("rst_dpoutready", 64'(dp_out_ready), 64'd0);
    check_val("rst_lenerr", 64'(len_err), 64'd0);

    // T1: single requester, 4 beats
    do_reset();
    exp_push(0, 0, 110); exp_push(0, 0, 112); exp_push(0, 0, 114); exp_push(0, 1, 116);
    send(0, 4, 4, 10, 100);
    wait_rsp("t1");
    check_grant("t1_grant", 0, 0);
    check_val("t1_grant_n", 64'(glog.size()), 64'd1);
    check_val("t1_busy_ge4", 64'(busy_cnt >= 4), 64'd1);
    check_val("t1_fifo_empty", 64'(dp_out_ready), 64'd0);

    // T2: requesters 1 and 3 simultaneously
    do_reset();
    exp_push(1, 0, 220); exp_push(1, 0, 222); exp_push(1, 1, 224);
    exp_push(3, 0, 330); exp_push(3, 0, 332); exp_push(3, 1, 334);
    fork
      send(1, 3, 3, 20, 200);
      send(3, 3, 3, 30, 300);
    join
    wait_rsp("t2");
    check_grant("t2_first", 0, 1);
    check_grant("t2_second", 1, 3);

    // T3: x end three cycles ahead of y end, then rr pointer observed
    do_reset();
    exp_push(2, 0, 440); exp_push(2, 0, 442); exp_push(2, 1, 444);
    exp_push(3, 0, 660); exp_push(3, 1, 662);
    exp_push(0, 0, 550); exp_push(0, 1, 552);
    fork
      begin
        drive_side(2, 1'b0, 3, 40, 0);
        #1;
        check_val("t3_xready_off_a", 64'(req_x_ready[2]), 64'd0);
        check_val("t3_busy_held_a", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check_val("t3_xready_off_b", 64'(req_x_ready[2]), 64'd0);
        check_val("t3_busy_held_b", 64'(busy), 64'd1);
      end
      begin
        drive_side(2, 1'b1, 3, 400, 3);
        #1;
        check_val("t3_idle_after_y", 64'(busy), 64'd0);
      end
    join
    fork
      send(0, 2, 2, 50, 500);
      send(3, 2, 2, 60, 600);
    join
    wait_rsp("t3");
    check_grant("t3_g0", 0, 2);
    check_grant("t3_rr_g1", 1, 3);
    check_grant("t3_rr_g2", 2, 0);

    // T4: two-entry tag FIFO, results held back, three requesters queue
    do_reset();
    rsp_ready = '0;
    exp_push(0, 0, 3);  exp_push(0, 1, 5);
    exp_push(1, 0, 10); exp_push(1, 1, 12);
    exp_push(2, 0, 15); exp_push(2, 1, 17);
    fork
      send(0, 2, 2, 1, 2);
      send(1, 2, 2, 5, 5);
      send(2, 2, 2, 7, 8);
      begin
        repeat (40) @(negedge clk);
        #1;
        check_val("t4_held_grants", 64'(glog.size()), 64'd2);
        check_val("t4_held_busy", 64'(busy), 64'd0);
        rsp_ready = '1;
      end
    join
    wait_rsp("t4");
    check_grant("t4_g2", 2, 2);
    check_val("t4_grant_after_pop",
              64'((gcyc.size() > 2) && (first_pop >= 0) && (gcyc[2] > first_pop)), 64'd1);

    // T5: rsp_ready[0] toggling through a 6-beat result
    do_reset();
    exp_push(0, 0, 770); exp_push(0, 0, 772); exp_push(0, 0, 774);
    exp_push(0, 0, 776); exp_push(0, 0, 778); exp_push(0, 1, 780);
    chk_mirror = 1;
    toggle_en = 1;
    send(0, 6, 6, 70, 700);
    wait_rsp("t5");
    chk_mirror = 0;
    toggle_en = 0;
    #2;
    rsp_ready = '1;
    check_val("t5_no_len_err", 64'(len_err), 64'd0);

    // T6: 5 x beats against 4 y beats
    do_reset();
    send(0, 5, 4, 80, 800);
    #1;
    check_val("t6_len_err", 64'(len_err), 64'd1);
    check_val("t6_idle", 64'(busy), 64'd0);

    // T7: reset in the middle of a packet
    @(negedge clk);
    xd[1] = 32'd90; yd[1] = 32'd900; xe[1] = 1'b0; ye[1] = 1'b0;
    xv[1] = 1'b1; yv[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("t6_len_err_hold", 64'(len_err), 64'd1);
    check_val("t7_busy_pre", 64'(busy), 64'd1);
    check_val("t7_grant_pre", 64'(grant_id), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("t7_busy", 64'(busy), 64'd0);
    check_val("t7_grant", 64'(grant_id), 64'd0);
    check_val("t7_xready", 64'(req_x_ready), 64'd0);
    check_val("t7_yready", 64'(req_y_ready), 64'd0);
    check_val("t7_dpxvalid", 64'(dp_x_valid), 64'd0);
    check_val("t7_rspvalid", 64'(rsp_valid), 64'd0);
    check_val("t7_dpoutready", 64'(dp_out_ready), 64'd0);
    check_val("t7_lenerr", 64'(len_err), 64'd0);
    xv[1] = 1'b0;
    yv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
